// File: rtl/axis_sample_source_if.sv
// AXI4-Stream sample channel between the sample source and the filter chain.
interface axis_sample_source_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_sample_source.sv
// Processor-side sample FIFO feeding an AXI4-Stream master with a bypassable
// output register, per-frame tlast marking and sticky overflow status.
module axis_sample_source #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 256
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  axis_sample_source_if.master     m_axis_data
);

  localparam int FD = DEPTH - 1;
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [DATA_W-1:0] mem_q [FD];
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d, fifo_cnt;
  logic [FW-1:0]     frame_q, frame_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              overflow_q, overflow_d;
  logic              hs, push_ok, load, fifo_we, tlast;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
  endfunction

  assign tlast = tvalid_q && (frame_q == FW'(FRAME_LEN - 1));

  always_comb begin
    hs       = tvalid_q && m_axis_data.tready;
    push_ok  = wr_en && (count_q != CW'(DEPTH));
    load     = !tvalid_q || hs;
    // count includes the output register, so the FIFO proper holds count - tvalid
    fifo_cnt = count_q - CW'(tvalid_q);

    rd_d       = rd_q;
    wr_d       = wr_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    frame_d    = frame_q;
    fifo_we    = 1'b0;
    count_d    = count_q + CW'(push_ok) - CW'(hs);
    overflow_d = overflow_q | (wr_en & ~push_ok);

    if (load) begin
      if (fifo_cnt != '0) begin
        tdata_d  = mem_q[rd_q];
        tvalid_d = 1'b1;
        rd_d     = ptr_inc(rd_q);
        fifo_we  = push_ok;
      end else if (push_ok) begin
        tdata_d  = wr_data;
        tvalid_d = 1'b1;
      end else begin
        tvalid_d = 1'b0;
      end
    end else begin
      fifo_we = push_ok;
    end

    if (fifo_we) wr_d = ptr_inc(wr_q);

    if (hs) frame_d = tlast ? '0 : frame_q + 1'b1;

    if (clr) begin
      rd_d       = '0;
      wr_d       = '0;
      tdata_d    = '0;
      tvalid_d   = 1'b0;
      frame_d    = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      fifo_we    = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_q       <= '0;
      wr_q       <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      frame_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      frame_q    <= frame_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (fifo_we) mem_q[wr_q] <= wr_data;
  end

  assign m_axis_data.tdata  = tdata_q;
  assign m_axis_data.tvalid = tvalid_q;
  assign m_axis_data.tlast  = tlast;
  assign full               = (count_q == CW'(DEPTH));
  assign empty              = (count_q == '0);
  assign level              = count_q;
  assign overflow           = overflow_q;

endmodule
